// File: rtl/isqrt_128b.sv
// isqrt_128b: sequential restoring integer square root with valid/ready handshakes.
// Takes a WIDTH_IN-bit radicand and returns the floor root (WIDTH_IN/2 bits) and the
// remainder (WIDTH_IN/2+1 bits). DIGITS_PER_CYCLE root bits are resolved per clock.
// Optional build macro ISQRT_EXACT_EN adds out_exact, set when the remainder is zero.
// Parameter legality: WIDTH_IN even, DIGITS_PER_CYCLE in {1,2,4} and dividing WIDTH_IN/2.

module isqrt_128b #(
    parameter int unsigned WIDTH_IN         = 128,
    parameter int unsigned DIGITS_PER_CYCLE = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH_IN-1:0]     in0,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH_IN/2-1:0]   out0,
    output logic [WIDTH_IN/2:0]     out_rem
`ifdef ISQRT_EXACT_EN
    ,
    output logic                    out_exact
`endif
);

    localparam int unsigned RW = WIDTH_IN / 2;                     // root width
    localparam int unsigned MW = RW + 2;                           // internal remainder width
    localparam int unsigned N  = WIDTH_IN / (2 * DIGITS_PER_CYCLE); // CALC cycles per result
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e                state_q;
    logic [WIDTH_IN-1:0]   x_q, x_n;
    logic [RW-1:0]         r_q, r_n;
    logic [MW-1:0]         m_q, m_n;
    logic [MW-1:0]         m_t, t_t;
    logic [CW-1:0]         cnt_q;

    // Idle is the only state that accepts a new operand.
    assign in_ready = (state_q == StIdle);

    // DIGITS_PER_CYCLE chained restoring digit steps from the current X/R/M.
    always_comb begin
        x_n = x_q;
        r_n = r_q;
        m_n = m_q;
        m_t = '0;
        t_t = '0;
        for (int i = 0; i < int'(DIGITS_PER_CYCLE); i++) begin
            // Top bits of m_n are zero by invariant, so the shift never loses data.
            m_t = (m_n << 2) | MW'(x_n[WIDTH_IN-1 -: 2]);
            t_t = {r_n, 2'b01};
            if (m_t >= t_t) begin
                m_n = m_t - t_t;
                r_n = (r_n << 1) | RW'(1);
            end else begin
                m_n = m_t;
                r_n = r_n << 1;
            end
            x_n = x_n << 2;
        end
    end

    // Control FSM plus datapath registers; outputs load only on DONE entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            x_q       <= '0;
            r_q       <= '0;
            m_q       <= '0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out0      <= '0;
            out_rem   <= '0;
`ifdef ISQRT_EXACT_EN
            out_exact <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        x_q     <= in0;
                        r_q     <= '0;
                        m_q     <= '0;
                        cnt_q   <= '0;
                        state_q <= StCalc;
                    end
                end
                StCalc: begin
                    x_q   <= x_n;
                    r_q   <= r_n;
                    m_q   <= m_n;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(N - 1)) begin
                        state_q   <= StDone;
                        out_valid <= 1'b1;
                        out0      <= r_n;
                        out_rem   <= m_n[RW:0];
`ifdef ISQRT_EXACT_EN
                        out_exact <= (m_n == '0);
`endif
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q   <= StIdle;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
